div_seq_ctrl: RTL and testbench

- Iterative 32-cycle radix-2 restoring divider and its sequencing controller.
- Serves the EX-stage DIV/DIVU handshake. EX holds div_start high while div_ready is low, and the stall request equals div_start.
- Quotient goes to LO and remainder to HI at writeback.
- Owns operand capture, sign handling, divide-by-zero early-out, pipeline-flush cancel and result hold under downstream stall.

---
 rtl/div_seq_if.sv | 28 ++
 rtl/div_seq_ctrl.sv | 117 +++++++++++
 tb/tb_div_seq_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// EX-stage <-> divider handshake bundle. The EX side (master) raises div_start
// with operands and waits for div_ready; the divider (slave) returns the
// registered quotient/remainder and a busy indication.
`timescale 1ns/1ps
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic             div_start;
   logic             div_signed;
   logic [WIDTH-1:0] opr1;
   logic [WIDTH-1:0] opr2;
   logic             flush;
   logic             stall;
   logic             div_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             busy;

   modport master (
      output div_start, div_signed, opr1, opr2, flush, stall,
      input  div_ready, quotient, remainder, busy
   );

   modport slave (
      input  div_start, div_signed, opr1, opr2, flush, stall,
      output div_ready, quotient, remainder, busy
   );
endinterface

// File: rtl/div_seq_ctrl.sv
// Iterative radix-2 restoring divider with its sequencing controller.
// Operands are captured as magnitudes, WIDTH restoring steps build the
// quotient in the shift register, and a final FIX cycle reapplies signs.
// Divide-by-zero skips the iteration and returns all-ones / raw dividend.
`timescale 1ns/1ps
module div_seq_ctrl #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   div_seq_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [2:0] {
      IDLE,
      DIV,
      FIX,
      DZ,
      DONE
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] part_rem;
   logic [WIDTH-1:0] shf;
   logic             q_neg;
   logic             r_neg;
   logic [WIDTH-1:0] quo_hold;
   logic [WIDTH-1:0] rem_hold;

   logic [WIDTH-1:0] abs1;
   logic [WIDTH-1:0] abs2;
   logic [WIDTH:0]   rem_shifted;
   logic [WIDTH:0]   trial;
   logic             borrow;

   // Operand magnitudes and the trial subtraction for one restoring step.
   always_comb begin
      abs1        = (bus.div_signed && bus.opr1[WIDTH-1]) ? -bus.opr1 : bus.opr1;
      abs2        = (bus.div_signed && bus.opr2[WIDTH-1]) ? -bus.opr2 : bus.opr2;
      rem_shifted = {part_rem, shf[WIDTH-1]};
      trial       = rem_shifted - {1'b0, divisor};
      borrow      = trial[WIDTH];
   end

   // Controller and datapath: accept, iterate, fix signs, hold result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         divisor  <= '0;
         part_rem <= '0;
         shf      <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         quo_hold <= '0;
         rem_hold <= '0;
      end else if (bus.flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.div_start) begin
                  divisor  <= abs2;
                  part_rem <= '0;
                  cnt      <= '0;
                  q_neg    <= bus.div_signed & (bus.opr1[WIDTH-1] ^ bus.opr2[WIDTH-1]);
                  r_neg    <= bus.div_signed & bus.opr1[WIDTH-1];
                  if (bus.opr2 == '0) begin
                     shf   <= bus.opr1;
                     state <= DZ;
                  end else begin
                     shf   <= abs1;
                     state <= DIV;
                  end
               end
            end
            DIV: begin
               part_rem <= borrow ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
               shf      <= {shf[WIDTH-2:0], ~borrow};
               cnt      <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               quo_hold <= q_neg ? -shf : shf;
               rem_hold <= r_neg ? -part_rem : part_rem;
               state    <= DONE;
            end
            DZ: begin
               quo_hold <= '1;
               rem_hold <= shf;
               state    <= DONE;
            end
            DONE: begin
               if (!bus.stall) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.div_ready = (state == DONE);
   assign bus.busy      = (state == DIV) || (state == FIX);
   assign bus.quotient  = quo_hold;
   assign bus.remainder = rem_hold;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed corner cases, stall hold,
// flush cancel, asynchronous reset mid-run and randomized divisions checked
// against an arithmetic reference model.
`timescale 1ns/1ps
module tb_div_seq_ctrl;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   logic [31:0] last_q;
   logic [31:0] last_r;

   div_seq_if #(.WIDTH(32)) bus ();

   div_seq_ctrl #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net in case a wait is ever left unbounded.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: plain arithmetic; SV signed division truncates toward zero
   // and the remainder takes the dividend's sign, matching DIV semantics.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 input logic sgn,
                                 output logic [31:0] q, output logic [31:0] r);
      longint sa;
      longint sb;
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (!sgn) begin
         q = a / b;
         r = a % b;
      end else begin
         q = 32'(sa / sb);
         r = 32'(sa % sb);
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Run one division through the EX handshake, optionally holding stall
   // high for nstall cycles after div_ready appears.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic sgn, input int nstall);
      logic [31:0] eq;
      logic [31:0] er;
      int          lat;
      int          busy_cnt;
      model(a, b, sgn, eq, er);
      @(negedge clk);
      bus.div_start  = 1'b1;
      bus.div_signed = sgn;
      bus.opr1       = a;
      bus.opr2       = b;
      bus.stall      = (nstall > 0);
      @(posedge clk);
      #1;
      busy_cnt       = int'(bus.busy);
      bus.opr1       = $urandom;
      bus.opr2       = $urandom;
      bus.div_signed = 1'($urandom);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk);
         #1;
         if (bus.div_ready) begin
            lat = n;
            break;
         end
         busy_cnt += int'(bus.busy);
      end
      bus.div_start = 1'b0;
      checkOutput("latency", 32'(lat), (b == 32'd0) ? 32'd1 : 32'd33);
      checkOutput("busy_cycles", 32'(busy_cnt), (b == 32'd0) ? 32'd0 : 32'd33);
      checkOutput("quotient", bus.quotient, eq);
      checkOutput("remainder", bus.remainder, er);
      for (int k = 0; k < nstall; k++) begin
         @(posedge clk);
         #1;
         checkOutput("stall_ready", 32'(bus.div_ready), 32'd1);
         checkOutput("stall_quotient", bus.quotient, eq);
         checkOutput("stall_remainder", bus.remainder, er);
      end
      bus.stall = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ready_drop", 32'(bus.div_ready), 32'd0);
      checkOutput("hold_quotient", bus.quotient, eq);
      @(posedge clk);
      #1;
      checkOutput("no_reaccept_busy", 32'(bus.busy), 32'd0);
      checkOutput("no_reaccept_ready", 32'(bus.div_ready), 32'd0);
      last_q = eq;
      last_r = er;
   endtask

   initial begin
      int          ready_seen;
      logic [31:0] ra;
      logic [31:0] rb;
      vectors        = 0;
      miscompares    = 0;
      last_q         = '0;
      last_r         = '0;
      bus.div_start  = 1'b0;
      bus.div_signed = 1'b0;
      bus.opr1       = '0;
      bus.opr2       = '0;
      bus.flush      = 1'b0;
      bus.stall      = 1'b0;
      rst            = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_quotient", bus.quotient, 32'd0);
      checkOutput("reset_remainder", bus.remainder, 32'd0);
      checkOutput("reset_ready", 32'(bus.div_ready), 32'd0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      rst = 1'b0;

      // Directed corner cases.
      applyStimulus(32'd100, 32'd7, 1'b0, 0);
      applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
      applyStimulus(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
      applyStimulus(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
      applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
      applyStimulus(32'h1234_5678, 32'd0, 1'b0, 0);
      applyStimulus(32'hFFFF_FFF9, 32'd0, 1'b1, 0);

      // Result hold under downstream stall.
      applyStimulus(32'd100, 32'd7, 1'b0, 5);

      // Flush cancels an in-flight division without touching the outputs.
      @(negedge clk);
      bus.div_start  = 1'b1;
      bus.div_signed = 1'b0;
      bus.opr1       = 32'd1000;
      bus.opr2       = 32'd3;
      @(posedge clk);
      repeat (9) @(posedge clk);
      #1;
      bus.flush     = 1'b1;
      bus.div_start = 1'b0;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      checkOutput("flush_busy", 32'(bus.busy), 32'd0);
      checkOutput("flush_ready", 32'(bus.div_ready), 32'd0);
      checkOutput("flush_quotient", bus.quotient, last_q);
      checkOutput("flush_remainder", bus.remainder, last_r);
      ready_seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         ready_seen += int'(bus.div_ready) + int'(bus.busy);
      end
      checkOutput("flush_no_completion", 32'(ready_seen), 32'd0);
      applyStimulus(32'd100, 32'd7, 1'b0, 0);

      // Flush together with start in IDLE must not accept.
      @(negedge clk);
      bus.div_start = 1'b1;
      bus.flush     = 1'b1;
      bus.opr1      = 32'd50;
      bus.opr2      = 32'd0;
      @(posedge clk);
      #1;
      bus.div_start = 1'b0;
      bus.flush     = 1'b0;
      checkOutput("flush_start_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("flush_start_ready", 32'(bus.div_ready), 32'd0);

      // Asynchronous reset in the middle of iteration.
      @(negedge clk);
      bus.div_start = 1'b1;
      bus.opr1      = 32'hDEAD_BEEF;
      bus.opr2      = 32'd13;
      @(posedge clk);
      repeat (20) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_quotient", bus.quotient, 32'd0);
      checkOutput("async_rst_remainder", bus.remainder, 32'd0);
      checkOutput("async_rst_ready", 32'(bus.div_ready), 32'd0);
      checkOutput("async_rst_busy", 32'(bus.busy), 32'd0);
      bus.div_start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(32'hDEAD_BEEF, 32'd13, 1'b0, 0);

      // Randomized divisions, mixing signedness and divisor magnitudes.
      for (int i = 0; i < 16; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 20));
            2:       rb = -32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         applyStimulus(ra, rb, 1'($urandom), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
